// File: rtl/hazard_if.sv
// Hazard/stall control bundle between the pipeline datapath and the
// hazard stall controller. The pipeline drives the hazard sources; the
// controller drives the stage enables, bubbles, flush and counters.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic             IDEXmemRead;
  logic             IDEXregWr;
  logic [4:0]       IDEXrt;
  logic [4:0]       IDEXrd;
  logic             EXMEMmemRead;
  logic [4:0]       EXMEMrd;
  logic [4:0]       IFIDrs;
  logic [4:0]       IFIDrt;
  logic             IFIDusesRt;
  logic             branch;
  logic             branchTaken;
  logic             jump;
  logic             mdStart;
  logic             pcWrite;
  logic             IFIDwrite;
  logic             IFIDflush;
  logic             IDEXbubble;
  logic             IDEXhold;
  logic             EXMEMbubble;
  logic             mdBusy;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  modport master (
    output IDEXmemRead, IDEXregWr, IDEXrt, IDEXrd, EXMEMmemRead, EXMEMrd,
           IFIDrs, IFIDrt, IFIDusesRt, branch, branchTaken, jump, mdStart,
    input  pcWrite, IFIDwrite, IFIDflush, IDEXbubble, IDEXhold, EXMEMbubble,
           mdBusy, stallCnt, flushCnt
  );

  modport slave (
    input  IDEXmemRead, IDEXregWr, IDEXrt, IDEXrd, EXMEMmemRead, EXMEMrd,
           IFIDrs, IFIDrt, IFIDusesRt, branch, branchTaken, jump, mdStart,
    output pcWrite, IFIDwrite, IFIDflush, IDEXbubble, IDEXhold, EXMEMbubble,
           mdBusy, stallCnt, flushCnt
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS core. Detects
// load-use and branch-in-ID hazards, holds EX for multi-cycle mul/div,
// flushes IF/ID on taken branches/jumps and counts stall/flush cycles.
module hazard_stall_controller #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave bus
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] BR_WAIT = 2'd1;
  localparam logic [1:0] MD_WAIT = 2'd2;

  // mdCnt only needs to reach MD_LATENCY-2; the RUN entry cycle and the
  // final mdCnt==0 cycle make up the rest of the hold.
  localparam int MDC_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
  localparam logic [MDC_W-1:0] MD_INIT = MDC_W'(MD_LATENCY - 2);

  logic [1:0]       state, state_nxt;
  logic [MDC_W-1:0] md_cnt, md_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic pc_write, ifid_write, ifid_flush, idex_bubble;
  logic idex_hold, exmem_bubble, md_busy;
  logic lu, ba, bl, bm;

  // Saturating increment: the counters stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Register-equality test that never matches on $zero.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // Hazard terms seen by the instruction sitting in ID.
  always_comb begin
    lu = bus.IDEXmemRead &&
         (reg_match(bus.IDEXrt, bus.IFIDrs) ||
          (bus.IFIDusesRt && reg_match(bus.IDEXrt, bus.IFIDrt)));
    ba = bus.branch && bus.IDEXregWr && !bus.IDEXmemRead &&
         (reg_match(bus.IDEXrd, bus.IFIDrs) || reg_match(bus.IDEXrd, bus.IFIDrt));
    bl = bus.branch && bus.IDEXmemRead &&
         (reg_match(bus.IDEXrt, bus.IFIDrs) || reg_match(bus.IDEXrt, bus.IFIDrt));
    bm = bus.branch && bus.EXMEMmemRead &&
         (reg_match(bus.EXMEMrd, bus.IFIDrs) || reg_match(bus.EXMEMrd, bus.IFIDrt));
  end

  // Next-state and output decode; outputs are Mealy from state plus hazards.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    state_nxt    = state;
    md_cnt_nxt   = md_cnt;
    case (state)
      RUN: begin
        if (bus.mdStart) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_hold    = 1'b1;
          exmem_bubble = 1'b1;
          state_nxt    = MD_WAIT;
          md_cnt_nxt   = MD_INIT;
        end else if (bl) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_nxt   = BR_WAIT;
        end else if (lu || ba || bm) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if ((bus.branch && bus.branchTaken) || bus.jump) begin
          ifid_flush = 1'b1;
        end
      end
      BR_WAIT: begin
        // Load result reaches MEM only now; second stall is unconditional.
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_nxt   = RUN;
      end
      MD_WAIT: begin
        // Flush is deferred: a waiting taken branch re-evaluates in RUN.
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_hold    = 1'b1;
        exmem_bubble = 1'b1;
        md_busy      = 1'b1;
        if (md_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          md_cnt_nxt = md_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt  = RUN;
        md_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state and mul/div countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) stall_cnt <= sat_inc(stall_cnt);
      if (ifid_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.pcWrite     = pc_write;
  assign bus.IFIDwrite   = ifid_write;
  assign bus.IFIDflush   = ifid_flush;
  assign bus.IDEXbubble  = idex_bubble;
  assign bus.IDEXhold    = idex_hold;
  assign bus.EXMEMbubble = exmem_bubble;
  assign bus.mdBusy      = md_busy;
  assign bus.stallCnt    = stall_cnt;
  assign bus.flushCnt    = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: main DUT with CNT_W=16 and a
// second DUT with CNT_W=4 for counter saturation.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  // {pcWrite, IFIDwrite, IFIDflush, IDEXbubble, IDEXhold, EXMEMbubble, mdBusy}
  localparam logic [6:0] IDLE  = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0001000;
  localparam logic [6:0] FLUSH = 7'b1110000;
  localparam logic [6:0] MDE   = 7'b0000110;
  localparam logic [6:0] MDW   = 7'b0000111;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(16)) bus ();
  hazard_if #(.CNT_W(4))  bus2 ();

  hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  function automatic logic [6:0] outs();
    return {bus.pcWrite, bus.IFIDwrite, bus.IFIDflush, bus.IDEXbubble,
            bus.IDEXhold, bus.EXMEMbubble, bus.mdBusy};
  endfunction

  task automatic clear_inputs();
    bus.IDEXmemRead = 0; bus.IDEXregWr = 0; bus.IDEXrt = 0; bus.IDEXrd = 0;
    bus.EXMEMmemRead = 0; bus.EXMEMrd = 0; bus.IFIDrs = 0; bus.IFIDrt = 0;
    bus.IFIDusesRt = 0; bus.branch = 0; bus.branchTaken = 0; bus.jump = 0;
    bus.mdStart = 0;
  endtask

  task automatic clear_inputs2();
    bus2.IDEXmemRead = 0; bus2.IDEXregWr = 0; bus2.IDEXrt = 0; bus2.IDEXrd = 0;
    bus2.EXMEMmemRead = 0; bus2.EXMEMrd = 0; bus2.IFIDrs = 0; bus2.IFIDrt = 0;
    bus2.IFIDusesRt = 0; bus2.branch = 0; bus2.branchTaken = 0; bus2.jump = 0;
    bus2.mdStart = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    clear_inputs2();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL reset_outs got %b want %b", outs(), IDLE); end
    checks++;
    if (bus.stallCnt !== 16'd0 || bus.flushCnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stallCnt, bus.flushCnt);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL post_reset_outs got %b want %b", outs(), IDLE); end
  endtask

  task automatic test_load_use();
    @(negedge clk) clear_inputs();
    bus.IDEXmemRead = 1; bus.IDEXrt = 8; bus.IFIDrs = 8;
    #1; checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL lu_rs got %b want %b", outs(), STALL); end
    exp_stall++;
    @(negedge clk) clear_inputs();
    #1; checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL lu_single got %b want %b", outs(), IDLE); end
    checks++;
    if (bus.stallCnt !== 16'(exp_stall)) begin errors++; $display("FAIL lu_cnt got %0d want %0d", bus.stallCnt, exp_stall); end
    // Register 0 never creates a hazard.
    @(negedge clk) clear_inputs();
    bus.IDEXmemRead = 1; bus.IFIDusesRt = 1;
    #1; checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL lu_r0 got %b want %b", outs(), IDLE); end
    // rt match only counts when ID actually reads rt.
    @(negedge clk) clear_inputs();
    bus.IDEXmemRead = 1; bus.IDEXrt = 12; bus.IFIDrt = 12; bus.IFIDrs = 3;
    #1; checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL lu_rt_unused got %b want %b", outs(), IDLE); end
    @(negedge clk) bus.IFIDusesRt = 1;
    #1; checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL lu_rt_used got %b want %b", outs(), STALL); end
    exp_stall++;
    @(negedge clk) clear_inputs();
    #1; checks++;
    if (bus.stallCnt !== 16'(exp_stall)) begin errors++; $display("FAIL lu_cnt2 got %0d want %0d", bus.stallCnt, exp_stall); end
  endtask

  task automatic test_branch_load();
    @(negedge clk) clear_inputs();
    bus.branch = 1; bus.IFIDrt = 9; bus.IDEXmemRead = 1; bus.IDEXrt = 9;
    #1; checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL bl_run got %b want %b", outs(), STALL); end
    exp_stall++;
    // BR_WAIT stalls regardless of a now-taken branch.
    @(negedge clk) bus.IDEXmemRead = 0; bus.IDEXrt = 0; bus.branchTaken = 1;
    #1; checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL bl_wait got %b want %b", outs(), STALL); end
    exp_stall++;
    @(negedge clk);
    #1; checks++;
    if (outs() !== FLUSH) begin errors++; $display("FAIL bl_flush got %b want %b", outs(), FLUSH); end
    exp_flush++;
    @(negedge clk) clear_inputs();
    #1; checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL bl_idle got %b want %b", outs(), IDLE); end
    checks++;
    if (bus.stallCnt !== 16'(exp_stall) || bus.flushCnt !== 16'(exp_flush)) begin
      errors++; $display("FAIL bl_cnt got %0d/%0d want %0d/%0d", bus.stallCnt, bus.flushCnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_branch_alu();
    @(negedge clk) clear_inputs();
    bus.branch = 1; bus.IDEXregWr = 1; bus.IDEXrd = 5; bus.IFIDrs = 5;
    #1; checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL ba_stall got %b want %b", outs(), STALL); end
    exp_stall++;
    @(negedge clk) bus.IDEXregWr = 0; bus.IDEXrd = 0; bus.branchTaken = 1;
    #1; checks++;
    if (outs() !== FLUSH) begin errors++; $display("FAIL ba_flush got %b want %b", outs(), FLUSH); end
    exp_flush++;
    // A load in EX matching rd but not rt is neither BA nor BL.
    @(negedge clk) clear_inputs();
    bus.branch = 1; bus.IDEXregWr = 1; bus.IDEXmemRead = 1; bus.IDEXrd = 5; bus.IDEXrt = 3; bus.IFIDrs = 5;
    #1; checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL ba_load_excl got %b want %b", outs(), IDLE); end
    // Load in MEM feeding a branch: single stall.
    @(negedge clk) clear_inputs();
    bus.branch = 1; bus.EXMEMmemRead = 1; bus.EXMEMrd = 7; bus.IFIDrt = 7;
    #1; checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL bm_stall got %b want %b", outs(), STALL); end
    exp_stall++;
    @(negedge clk) clear_inputs();
    #1; checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL bm_single got %b want %b", outs(), IDLE); end
    checks++;
    if (bus.stallCnt !== 16'(exp_stall) || bus.flushCnt !== 16'(exp_flush)) begin
      errors++; $display("FAIL ba_cnt got %0d/%0d want %0d/%0d", bus.stallCnt, bus.flushCnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_muldiv();
    @(negedge clk) clear_inputs();
    bus.mdStart = 1; bus.jump = 1;
    #1; checks++;
    if (outs() !== MDE) begin errors++; $display("FAIL md_entry got %b want %b", outs(), MDE); end
    exp_stall++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) bus.mdStart = 0;
      #1; checks++;
      if (outs() !== MDW) begin errors++; $display("FAIL md_wait%0d got %b want %b", i, outs(), MDW); end
      exp_stall++;
    end
    @(negedge clk);
    #1; checks++;
    if (outs() !== FLUSH) begin errors++; $display("FAIL md_release got %b want %b", outs(), FLUSH); end
    exp_flush++;
    @(negedge clk) clear_inputs();
    #1; checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL md_idle got %b want %b", outs(), IDLE); end
    checks++;
    if (bus.stallCnt !== 16'(exp_stall) || bus.flushCnt !== 16'(exp_flush)) begin
      errors++; $display("FAIL md_cnt got %0d/%0d want %0d/%0d", bus.stallCnt, bus.flushCnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mid_md();
    @(negedge clk) clear_inputs();
    bus.mdStart = 1;
    @(negedge clk) bus.mdStart = 0;
    #1; checks++;
    if (outs() !== MDW) begin errors++; $display("FAIL rmd_hold2 got %b want %b", outs(), MDW); end
    #1 rst = 1'b1;
    #1; checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL rmd_async got %b want %b", outs(), IDLE); end
    checks++;
    if (bus.stallCnt !== 16'd0 || bus.flushCnt !== 16'd0) begin
      errors++; $display("FAIL rmd_cnt got %0d/%0d want 0/0", bus.stallCnt, bus.flushCnt);
    end
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk) rst = 1'b0;
    bus.IDEXmemRead = 1; bus.IDEXrt = 8; bus.IFIDrs = 8;
    #1; checks++;
    if (outs() !== STALL) begin errors++; $display("FAIL rmd_run_lu got %b want %b", outs(), STALL); end
    exp_stall++;
    @(negedge clk) clear_inputs();
    #1; checks++;
    if (outs() !== IDLE) begin errors++; $display("FAIL rmd_run_idle got %b want %b", outs(), IDLE); end
    checks++;
    if (bus.stallCnt !== 16'(exp_stall)) begin errors++; $display("FAIL rmd_cnt2 got %0d want %0d", bus.stallCnt, exp_stall); end
  endtask

  task automatic test_saturation();
    @(negedge clk) clear_inputs2();
    bus2.IDEXmemRead = 1; bus2.IDEXrt = 4; bus2.IFIDrs = 4;
    repeat (14) @(negedge clk);
    #1; checks++;
    if (bus2.stallCnt !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", bus2.stallCnt); end
    repeat (6) @(negedge clk);
    #1; checks++;
    if (bus2.stallCnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", bus2.stallCnt); end
    checks++;
    if (bus2.pcWrite !== 1'b0) begin errors++; $display("FAIL sat_stalling got %b want 0", bus2.pcWrite); end
    clear_inputs2();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_muldiv();
    test_reset_mid_md();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Sits beside the forwarding unit and decides when the front end freezes, when bubbles are injected, and when IF/ID is flushed.
- Covers three cases: load-use hazards, branch-in-ID hazards that forwarding cannot cover, and multi-cycle multiply/divide occupancy of EX.
- Also keeps saturating stall and flush performance counters.

Parameters:
- MD_LATENCY, 4, number of consecutive cycles a mul/div holds the pipeline (must be >= 2).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IDEXmemRead  in  1  instruction in EX is a load.
- IDEXregWr  in  1  instruction in EX writes a register.
- IDEXrt  in  5  load destination of the instruction in EX.
- IDEXrd  in  5  final (post-RegDst) destination of the instruction in EX.
- EXMEMmemRead  in  1  instruction in MEM is a load.
- EXMEMrd  in  5  destination of the instruction in MEM.
- IFIDrs  in  5  rs of the instruction in ID.
- IFIDrt  in  5  rt of the instruction in ID.
- IFIDusesRt  in  1  the instruction in ID reads rt as a source.
- branch  in  1  the instruction in ID is beq/bne.
- branchTaken  in  1  branch comparison in ID resolved taken.
- jump  in  1  the instruction in ID is j/jal.
- mdStart  in  1  the instruction in EX is mul/div.
- pcWrite  out  1  PC load enable.
- IFIDwrite  out  1  IF/ID load enable.
- IFIDflush  out  1  zero IF/ID on the next edge.
- IDEXbubble  out  1  load a NOP into ID/EX.
- IDEXhold  out  1  hold ID/EX contents.
- EXMEMbubble  out  1  load a NOP into EX/MEM.
- mdBusy  out  1  controller is in MD_WAIT.
- stallCnt  out  CNT_W  cycles with pcWrite=0, saturating.
- flushCnt  out  CNT_W  cycles with IFIDflush=1, saturating.

Behaviour:
- States: RUN, BR_WAIT, MD_WAIT. Internal mdCnt is wide enough for MD_LATENCY-2.
- Outputs are combinational from state plus inputs. State, mdCnt and the counters are registered.
- Reset (asynchronous, any state including mid-MD_WAIT or BR_WAIT):
  - state=RUN, mdCnt=0, stallCnt=0, flushCnt=0.
  - Outputs then follow RUN rules. Idle values: pcWrite=1, IFIDwrite=1, all others 0.
- Hazard terms (a register match never counts when that register is 0):
  - LU: IDEXmemRead && (IDEXrt==IFIDrs || (IFIDusesRt && IDEXrt==IFIDrt)).
  - BA: branch && IDEXregWr && !IDEXmemRead && IDEXrd matches IFIDrs or IFIDrt.
  - BL: branch && IDEXmemRead && IDEXrt matches IFIDrs or IFIDrt.
  - BM: branch && EXMEMmemRead && EXMEMrd matches IFIDrs or IFIDrt.
- RUN, priority order:
  1. mdStart: IDEXhold=1, EXMEMbubble=1, pcWrite=0, IFIDwrite=0.
     - Next state MD_WAIT with mdCnt=MD_LATENCY-2. All other terms are ignored.
  2. BL: pcWrite=0, IFIDwrite=0, IDEXbubble=1. Next state BR_WAIT.
  3. LU or BA or BM: pcWrite=0, IFIDwrite=0, IDEXbubble=1. Stay in RUN (single-cycle stall).
  4. (branch && branchTaken) || jump: IFIDflush=1. Pipeline otherwise advances.
  5. Otherwise idle values.
- BR_WAIT:
  - Unconditional second stall cycle: pcWrite=0, IFIDwrite=0, IDEXbubble=1.
  - mdStart and flush conditions are ignored. Next state RUN.
- MD_WAIT:
  - Same outputs as RUN case 1, plus mdBusy=1.
  - If mdCnt==0, next state RUN; else decrement mdCnt.
  - Total hold is exactly MD_LATENCY consecutive cycles, including the RUN entry cycle.
  - IFIDflush is never asserted in MD_WAIT. A taken branch waiting in ID is re-evaluated in RUN after release.
- IFIDflush is never asserted in the same cycle as pcWrite=0.
- Counters:
  - stallCnt increments on every clock with pcWrite=0.
  - flushCnt increments on every clock with IFIDflush=1.
  - Both hold at all-ones.

Test Plan:
- Load-use: IDEXmemRead=1, IDEXrt=8, IFIDrs=8, no branch -> one cycle of pcWrite=0, IFIDwrite=0, IDEXbubble=1, state stays RUN, stallCnt=1. Repeat with IDEXrt=0 -> no stall.
- Branch on load: branch=1, IFIDrt=9, IDEXmemRead=1, IDEXrt=9 -> two consecutive stall cycles (RUN then BR_WAIT), then idle, stallCnt=2.
- Branch on ALU result: branch=1, IDEXregWr=1, IDEXrd=5, IFIDrs=5 -> exactly one stall. Then branchTaken=1 with no hazard -> IFIDflush=1 for one cycle, flushCnt=1.
- Mul/div, MD_LATENCY=4: mdStart pulse in RUN -> IDEXhold=EXMEMbubble=1 and pcWrite=0 for exactly 4 cycles, mdBusy=1 for the last 3. A simultaneous jump=1 produces no flush until release, then a 1-cycle flush.
- Reset mid-MD_WAIT: assert rst asynchronously in the 2nd hold cycle -> outputs immediately idle, mdBusy=0, counters 0. After release, state RUN.
- Saturation: CNT_W=4, hold the LU condition 20 cycles -> stallCnt stops at 15.
